usb_ddr3_framer: RTL and testbench

Upstream stage of the DDR3 core. It consumes the raw 8-bit USB BULK OUT stream and decodes a 6-byte request header (opcode, byte address, word count). It emits one command per request on a command channel. For writes, it packs the following payload bytes into 32-bit words on a write-data stream. The result is a framed, word-wide interface suitable for a 32-bit DDR3 controller port.

---
 rtl/usb_ddr3_pkg.sv | 28 ++
 rtl/axis_byte_packer.sv | 81 ++++++++
 rtl/usb_ddr3_framer.sv | 194 +++++++++++++++++++
 tb/tb_usb_ddr3_framer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ddr3_pkg.sv
// Shared definitions for the USB-to-DDR3 request framer: FSM encoding,
// header geometry and default opcodes.
package usb_ddr3_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam int         HDR_BYTES      = 6;
  localparam logic [7:0] WR_OPCODE_DEF  = 8'h57;
  localparam logic [7:0] RD_OPCODE_DEF  = 8'h52;

  // Byte enables for a word whose highest filled lane is last_pos.
  function automatic logic [3:0] keep_mask(input logic [1:0] last_pos);
    logic [3:0] keep;
    case (last_pos)
      2'd0:    keep = 4'b0001;
      2'd1:    keep = 4'b0011;
      2'd2:    keep = 4'b0111;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words with keep/last, behind
// a single output register; counts words down from the request length.
module axis_byte_packer
  import usb_ddr3_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        emit,
  output logic        emit_full,
  output logic        cnt_zero,
  output logic        wr_tvalid,
  input  logic        wr_tready,
  output logic        wr_tlast,
  output logic [3:0]  wr_tkeep,
  output logic [31:0] wr_tdata
);

  logic [1:0]  pos_p0;
  logic [31:0] acc_p0;
  logic [7:0]  cnt_p0;
  logic        accept;

  // Lanes above the newest byte may hold stale data and are forced to zero.
  function automatic logic [31:0] pack_word(input logic [31:0] acc,
                                            input logic [7:0]  b,
                                            input logic [1:0]  pos);
    logic [31:0] w;
    logic [3:0]  keep;
    w = acc;
    w[{pos, 3'b000} +: 8] = b;
    keep = keep_mask(pos);
    for (int k = 0; k < 4; k++) begin
      if (!keep[k]) w[8*k +: 8] = 8'h00;
    end
    return w;
  endfunction

  assign in_ready  = !wr_tvalid || wr_tready;
  assign accept    = in_valid && in_ready;
  assign emit_full = (pos_p0 == 2'd3);
  assign cnt_zero  = (cnt_p0 == 8'd0);
  assign emit      = accept && (emit_full || in_last);

  // Stage p0: byte accumulator; stage p1: output word register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pos_p0    <= 2'd0;
      acc_p0    <= 32'h0;
      cnt_p0    <= 8'd0;
      wr_tvalid <= 1'b0;
      wr_tlast  <= 1'b0;
      wr_tkeep  <= 4'h0;
      wr_tdata  <= 32'h0;
    end else begin
      if (start) begin
        pos_p0 <= 2'd0;
        cnt_p0 <= len;
      end else if (accept) begin
        acc_p0[{pos_p0, 3'b000} +: 8] <= in_data;
        pos_p0 <= emit ? 2'd0 : pos_p0 + 2'd1;
        if (emit) cnt_p0 <= cnt_p0 - 8'd1;
      end

      if (emit) begin
        wr_tvalid <= 1'b1;
        wr_tdata  <= pack_word(acc_p0, in_data, pos_p0);
        wr_tkeep  <= keep_mask(pos_p0);
        wr_tlast  <= in_last || cnt_zero;
      end else if (wr_tready) begin
        wr_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/usb_ddr3_framer.sv
// Decodes 6-byte USB BULK OUT request headers into DDR3 commands and packs
// write payload bytes into 32-bit words.
module usb_ddr3_framer
  import usb_ddr3_pkg::*;
#(
  parameter int         ADDR_WIDTH = 27,
  parameter logic [7:0] WR_OPCODE  = WR_OPCODE_DEF,
  parameter logic [7:0] RD_OPCODE  = RD_OPCODE_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [7:0]            s_tdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_write,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic                  wr_tvalid,
  input  logic                  wr_tready,
  output logic                  wr_tlast,
  output logic [3:0]            wr_tkeep,
  output logic [31:0]           wr_tdata,
  output logic                  err_o
);

  localparam logic [2:0] LAST_IDX = 3'(HDR_BYTES - 1);

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic [31:0] addr_buf;
  logic        is_wr;
  logic        pend_drop, pend_next;
  logic        err_next;
  logic        hdr_load;
  logic        pk_start;
  logic        accept;
  logic        op_ok;
  logic        pk_ready, pk_emit, pk_full, pk_cnt_zero;
  logic        unused_addr_bits;

  assign accept = s_tvalid && s_tready;
  assign op_ok  = (s_tdata == WR_OPCODE) || (s_tdata == RD_OPCODE);
  assign unused_addr_bits = ^{addr_buf[31:ADDR_WIDTH], addr_buf[1:0]};

  always_comb begin
    s_tready = 1'b0;
    case (state)
      ST_HDR:  s_tready = !wr_tvalid;
      ST_CMD:  s_tready = 1'b0;
      ST_DATA: s_tready = pk_ready;
      ST_DROP: s_tready = 1'b1;
      default: s_tready = 1'b0;
    endcase
    s_tready = s_tready && reset_n;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    pend_next  = pend_drop;
    err_next   = 1'b0;
    hdr_load   = 1'b0;
    pk_start   = 1'b0;
    case (state)
      ST_HDR: begin
        if (accept) begin
          if (idx == 3'd0) begin
            idx_next = 3'd0;
            if (!op_ok) begin
              err_next = 1'b1;
              if (!s_tlast) state_next = ST_DROP;
            end else if (s_tlast) begin
              err_next = 1'b1;
            end else begin
              idx_next = 3'd1;
            end
          end else if (idx != LAST_IDX) begin
            if (s_tlast) begin
              err_next = 1'b1;
              idx_next = 3'd0;
            end else begin
              idx_next = idx + 3'd1;
            end
          end else begin
            idx_next = 3'd0;
            if (!is_wr) begin
              hdr_load   = 1'b1;
              state_next = ST_CMD;
              pend_next  = !s_tlast;
              err_next   = !s_tlast;
            end else if (s_tlast) begin
              err_next = 1'b1;
            end else begin
              hdr_load   = 1'b1;
              state_next = ST_CMD;
              pend_next  = 1'b0;
            end
          end
        end
      end
      ST_CMD: begin
        if (cmd_valid && cmd_ready) begin
          pend_next = 1'b0;
          if (cmd_write) begin
            state_next = ST_DATA;
            pk_start   = 1'b1;
          end else begin
            state_next = pend_drop ? ST_DROP : ST_HDR;
          end
        end
      end
      ST_DATA: begin
        if (pk_emit) begin
          if (pk_full && pk_cnt_zero) begin
            if (s_tlast) begin
              state_next = ST_HDR;
            end else begin
              err_next   = 1'b1;
              state_next = ST_DROP;
            end
          end else if (s_tlast) begin
            err_next   = 1'b1;
            state_next = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_tlast) state_next = ST_HDR;
      end
      default: state_next = ST_HDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_HDR;
      idx       <= 3'd0;
      pend_drop <= 1'b0;
      err_o     <= 1'b0;
      addr_buf  <= 32'h0;
      is_wr     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= 8'd0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      pend_drop <= pend_next;
      err_o     <= err_next;

      // Address bytes arrive little-endian, so shift each one in from the top.
      if (state == ST_HDR && accept) begin
        if (idx == 3'd0) begin
          is_wr <= (s_tdata == WR_OPCODE);
        end else if (idx != LAST_IDX) begin
          addr_buf <= {s_tdata, addr_buf[31:8]};
        end
      end

      if (hdr_load) begin
        cmd_valid <= 1'b1;
        cmd_write <= is_wr;
        cmd_addr  <= {addr_buf[ADDR_WIDTH-1:2], 2'b00};
        cmd_len   <= s_tdata;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  axis_byte_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (pk_start),
    .len       (cmd_len),
    .in_valid  (s_tvalid && (state == ST_DATA)),
    .in_data   (s_tdata),
    .in_last   (s_tlast),
    .in_ready  (pk_ready),
    .emit      (pk_emit),
    .emit_full (pk_full),
    .cnt_zero  (pk_cnt_zero),
    .wr_tvalid (wr_tvalid),
    .wr_tready (wr_tready),
    .wr_tlast  (wr_tlast),
    .wr_tkeep  (wr_tkeep),
    .wr_tdata  (wr_tdata)
  );

endmodule

// File: tb/tb_usb_ddr3_framer.sv
// Scoreboard bench for usb_ddr3_framer: expected commands and words are
// queued as requests are driven and checked as the DUT hands them off.
module tb_usb_ddr3_framer;

  localparam int AW = 27;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [7:0]    s_tdata = 8'h00;
  logic          cmd_valid;
  logic          cmd_ready = 1'b1;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wr_tvalid;
  logic          wr_tready = 1'b1;
  logic          wr_tlast;
  logic [3:0]    wr_tkeep;
  logic [31:0]   wr_tdata;
  logic          err_o;

  always #5 clock = ~clock;

  usb_ddr3_framer #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .s_tdata   (s_tdata),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_tvalid (wr_tvalid),
    .wr_tready (wr_tready),
    .wr_tlast  (wr_tlast),
    .wr_tkeep  (wr_tkeep),
    .wr_tdata  (wr_tdata),
    .err_o     (err_o)
  );

  int          compared = 0;
  int          mismatched = 0;
  int          err_seen = 0;
  int          err_base = 0;
  int          bp_cnt = 0;
  logic [35:0] cmd_q[$];
  logic [36:0] word_q[$];
  logic [7:0]  frame[$];
  logic [7:0]  pay[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [35:0] ec;
    logic [36:0] ew;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (err_o) err_seen++;
        if (s_tvalid && !s_tready && wr_tvalid && !wr_tready) bp_cnt++;
        if (cmd_valid && cmd_ready) begin
          if (cmd_q.size() == 0) begin
            check_eq("cmd_unexpected", 64'(cmd_q.size()), 64'd1);
          end else begin
            ec = cmd_q.pop_front();
            check_eq("cmd", 64'({cmd_write, cmd_addr, cmd_len}), 64'(ec));
          end
        end
        if (wr_tvalid && wr_tready) begin
          if (word_q.size() == 0) begin
            check_eq("word_unexpected", 64'(word_q.size()), 64'd1);
          end else begin
            ew = word_q.pop_front();
            check_eq("word", 64'({wr_tdata, wr_tkeep, wr_tlast}), 64'(ew));
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = b;
    s_tlast  = last;
    n = 0;
    forever begin
      @(negedge clock);
      if (s_tready) begin
        @(posedge clock);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        check_eq("s_tready_timeout", 64'(n), 64'd0);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic mark_last);
    for (int i = 0; i < frame.size(); i++)
      send_byte(frame[i], mark_last && (i == frame.size() - 1));
    frame.delete();
  endtask

  task automatic push_hdr(input logic [7:0] op, input logic [31:0] addr, input logic [7:0] len);
    frame.push_back(op);
    for (int i = 0; i < 4; i++) frame.push_back(addr[8*i +: 8]);
    frame.push_back(len);
  endtask

  task automatic fill_pay(input int n, input logic [7:0] first, input logic [7:0] step);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(first + 8'(i) * step);
  endtask

  task automatic exp_cmd(input logic w, input logic [31:0] addr, input logic [7:0] len);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    a[1:0] = 2'b00;
    cmd_q.push_back({w, a, len});
  endtask

  // Reference packing: payload is cut at (len+1) words; the last chunk carries tlast.
  task automatic exp_words(input logic [7:0] len, output int exp_err);
    int n, cap, lim, cnt;
    logic [31:0] d;
    logic [3:0]  k;
    n   = pay.size();
    cap = 4 * (int'(len) + 1);
    lim = (n < cap) ? n : cap;
    for (int w = 0; 4 * w < lim; w++) begin
      cnt = lim - 4 * w;
      if (cnt > 4) cnt = 4;
      d = 32'h0;
      k = 4'h0;
      for (int b = 0; b < cnt; b++) begin
        d[8*b +: 8] = pay[4*w + b];
        k[b] = 1'b1;
      end
      word_q.push_back({d, k, (4 * w + 4 >= lim)});
    end
    exp_err = (n != cap) ? 1 : 0;
  endtask

  task automatic finish_test(input string tag, input int exp_err);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || word_q.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    check_eq({tag, "_cmd_left"}, 64'(cmd_q.size()), 64'd0);
    check_eq({tag, "_word_left"}, 64'(word_q.size()), 64'd0);
    check_eq({tag, "_err"}, 64'(err_seen - err_base), 64'(exp_err));
    cmd_q.delete();
    word_q.delete();
    @(posedge clock);
    #1;
    err_base = err_seen;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len);
    int e;
    if (pay.size() == 0) begin
      e = 1;
    end else begin
      exp_cmd(1'b1, addr, len);
      exp_words(len, e);
    end
    push_hdr(8'h57, addr, len);
    for (int i = 0; i < pay.size(); i++) frame.push_back(pay[i]);
    send_frame(1'b1);
    finish_test(tag, e);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len);
    exp_cmd(1'b0, addr, len);
    push_hdr(8'h52, addr, len);
    for (int i = 0; i < pay.size(); i++) frame.push_back(pay[i]);
    send_frame(1'b1);
    finish_test(tag, (pay.size() != 0) ? 1 : 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_s_tready", 64'(s_tready), 64'd0);
    check_eq("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check_eq("rst_wr_tvalid", 64'(wr_tvalid), 64'd0);
    check_eq("rst_fields", 64'({cmd_write, cmd_addr, cmd_len, wr_tkeep, wr_tlast, err_o}), 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("idle_s_tready", 64'(s_tready), 64'd1);

    // Single-word write.
    fill_pay(4, 8'h11, 8'h11);
    do_write("t1", 32'h0000_1234, 8'd0);

    // Two-word write with back-pressure on the first word.
    bp_cnt = 0;
    wr_tready = 1'b0;
    fork
      begin
        int n;
        n = 0;
        while (!wr_tvalid && n < 200) begin
          @(negedge clock);
          n++;
        end
        repeat (3) @(posedge clock);
        #1;
        wr_tready = 1'b1;
      end
    join_none
    fill_pay(8, 8'h11, 8'h11);
    do_write("t2", 32'h0000_0100, 8'd1);
    check_eq("t2_backpressure", 64'(bp_cnt > 0), 64'd1);

    // Read with the command channel held off.
    cmd_ready = 1'b0;
    exp_cmd(1'b0, 32'h0000_1000, 8'd7);
    push_hdr(8'h52, 32'h0000_1000, 8'd7);
    send_frame(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("t3_s_tready", 64'(s_tready), 64'd0);
      check_eq("t3_cmd_valid", 64'(cmd_valid), 64'd1);
    end
    @(posedge clock);
    #1;
    cmd_ready = 1'b1;
    finish_test("t3", 0);

    // Bad opcode followed by 7 bytes, then a normal write with high address bits.
    frame.push_back(8'hFF);
    for (int i = 0; i < 7; i++) frame.push_back(8'h52 + 8'(i));
    send_frame(1'b1);
    finish_test("t4_bad_op", 1);
    fill_pay(4, 8'hC0, 8'h01);
    do_write("t4_next", 32'h0ABC_DEF7, 8'd0);

    // Short payload: second word only half filled.
    fill_pay(6, 8'hB1, 8'h01);
    do_write("t5", 32'h0000_2000, 8'd1);

    // Reset mid-payload, then a fresh header.
    exp_cmd(1'b1, 32'h0000_0040, 8'd1);
    push_hdr(8'h57, 32'h0000_0040, 8'd1);
    frame.push_back(8'hD1);
    frame.push_back(8'hD2);
    send_frame(1'b0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_eq("t6_rst_valids", 64'({s_tready, cmd_valid, wr_tvalid, wr_tlast, err_o}), 64'd0);
    check_eq("t6_rst_data", 64'({wr_tdata, wr_tkeep}), 64'd0);
    check_eq("t6_rst_cmd", 64'({cmd_write, cmd_addr, cmd_len}), 64'd0);
    reset_n = 1'b1;
    finish_test("t6_reset", 0);
    fill_pay(4, 8'hA1, 8'h01);
    do_write("t6_fresh", 32'h0000_0080, 8'd0);

    // Read header with trailing bytes: command issued, tail dropped.
    fill_pay(3, 8'hE0, 8'h01);
    do_read("t7", 32'h0000_3004, 8'd2);

    // Write header ending on byte 5, and a header cut short.
    pay.delete();
    do_write("t8_nopay", 32'h0000_4000, 8'd0);
    frame.push_back(8'h57);
    frame.push_back(8'h00);
    frame.push_back(8'h10);
    send_frame(1'b1);
    finish_test("t8_short_hdr", 1);

    // Payload longer than the request: extra bytes dropped.
    fill_pay(6, 8'h71, 8'h01);
    do_write("t9_long", 32'h0000_5008, 8'd0);
    fill_pay(4, 8'h91, 8'h02);
    do_write("t9_next", 32'h0000_600C, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
